// File: rtl/aes0_seq_pkg.sv
// ----------------------------------------------------------------------------
// aes0_seq_pkg
// Shared definitions for the AES0 bus-initiator sequencer:
//   - seq_state_t : sequencer FSM state encoding
//   - IDX_*       : AES0 register word indices (byte address = idx << 3)
//   - key_base()  : first key word index for a key-bank select value
// ----------------------------------------------------------------------------
package aes0_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_W_KSEL   = 4'd1,
        S_W_KEY    = 4'd2,
        S_W_STATE  = 4'd3,
        S_W_PT     = 4'd4,
        S_W_START1 = 4'd5,
        S_W_START0 = 4'd6,
        S_POLL     = 4'd7,
        S_R_CT     = 4'd8,
        S_RESP     = 4'd9
    } seq_state_t;

    localparam logic [5:0] IDX_START = 6'd0;
    localparam logic [5:0] IDX_PT0   = 6'd1;
    localparam logic [5:0] IDX_KEY0  = 6'd5;
    localparam logic [5:0] IDX_VALID = 6'd11;
    localparam logic [5:0] IDX_CT0   = 6'd12;
    localparam logic [5:0] IDX_ST0   = 6'd16;
    localparam logic [5:0] IDX_KEY1  = 6'd20;
    localparam logic [5:0] IDX_KEY2  = 6'd26;
    localparam logic [5:0] IDX_KSEL  = 6'd32;

    // Banks 2 and 3 both map onto key2.
    function automatic logic [5:0] key_base(input logic [1:0] ksel);
        logic [5:0] base;
        case (ksel)
            2'd0:    base = IDX_KEY0;
            2'd1:    base = IDX_KEY1;
            default: base = IDX_KEY2;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/aes0_seq_bus_if.sv
// ----------------------------------------------------------------------------
// aes0_seq_bus_if
// Single-outstanding register-bus initiator. Takes one command at a time and
// drives it onto the req/gnt/rvalid bus.
//
// Handshake: a command transfers when i_cmd_valid & o_cmd_ready are both high
// on a rising edge; o_cmd_ready is low from acceptance until the cycle after
// o_done. o_done pulses for one cycle: on the grant cycle for a write, on the
// rvalid cycle for a read (o_rdata valid only with o_done of a read).
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready     command handshake
//   i_cmd_we, i_cmd_idx,        1 = write; word index; 32-bit write data
//   i_cmd_wdata
//   o_done, o_rdata             completion pulse, read data (low 32 bits)
//   o_bus_req/we/addr/wdata     bus request, held stable until i_bus_gnt
//   i_bus_gnt, i_bus_rvalid,    grant, read-data valid, read data
//   i_bus_rdata
// ----------------------------------------------------------------------------
module aes0_seq_bus_if #(
    parameter int ADDR_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [5:0]        i_cmd_idx,
    input  logic [31:0]       i_cmd_wdata,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [63:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [63:0]       i_bus_rdata
);

    logic        r_req;
    logic        r_we;
    logic        r_pend;   // read granted, waiting for rvalid
    logic [5:0]  r_idx;
    logic [31:0] r_wdata;
    logic        w_unused_rdata_hi;

    assign o_cmd_ready = !r_req && !r_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_pend  <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            if (i_cmd_valid && o_cmd_ready) begin
                r_req   <= 1'b1;
                r_we    <= i_cmd_we;
                r_idx   <= i_cmd_idx;
                r_wdata <= i_cmd_wdata;
            end else if (r_req && i_bus_gnt) begin
                r_req  <= 1'b0;
                r_pend <= !r_we;
            end else if (r_pend && i_bus_rvalid) begin
                r_pend <= 1'b0;
            end
        end
    end

    // rvalid only counts while a read is pending; stray pulses fall through.
    assign o_done  = (r_req && i_bus_gnt && r_we) || (r_pend && i_bus_rvalid);
    assign o_rdata = i_bus_rdata[31:0];
    assign w_unused_rdata_hi = ^i_bus_rdata[63:32];

    assign o_bus_req   = r_req;
    assign o_bus_we    = r_we;
    assign o_bus_wdata = {32'h0, r_wdata};

    always_comb begin
        o_bus_addr      = '0;
        o_bus_addr[8:3] = r_idx;
    end

endmodule

// File: rtl/aes0_seq_master.sv
// ----------------------------------------------------------------------------
// aes0_seq_master
// Requester-side sequencer for the AES0 peripheral. Accepts one job, writes
// key_sel, key bank, state, plaintext, pulses start, polls ct_valid and reads
// back the ciphertext over a single-outstanding register bus.
//
// Optional build macro AES0_SEQ_KEY_CACHE_EN: remembers {ksel, key} of the
// last successful job and skips key_sel/key writes when the next job matches.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   job_valid_i/job_ready_o       job handshake (ready while idle)
//   job_key_i/ksel_i/state_i/pt_i job fields, captured on accept
//   res_valid_o/res_ready_i       result handshake
//   res_ct_o, res_err_o           ciphertext, poll-timeout flag (held in RESP)
//   bus_*                         register-bus initiator signals
//   dbg_state_o                   current FSM state
// ----------------------------------------------------------------------------
module aes0_seq_master
    import aes0_seq_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int POLL_MAX = 1024,
    parameter int TO_W     = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [191:0]      job_key_i,
    input  logic [1:0]        job_ksel_i,
    input  logic [127:0]      job_state_i,
    input  logic [127:0]      job_pt_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [127:0]      res_ct_o,
    output logic              res_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [63:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [63:0]       bus_rdata_i,
    output logic [3:0]        dbg_state_o
);

    seq_state_t r_fsm, w_fsm_nxt;

    logic [2:0]      r_wcnt;
    logic [TO_W-1:0] r_poll;
    logic [191:0]    r_key;
    logic [1:0]      r_ksel;
    logic [127:0]    r_st;
    logic [127:0]    r_pt;
    logic [127:0]    r_ct;
    logic            r_err;

    logic            w_cmd_valid;
    logic            w_cmd_ready;
    logic            w_cmd_we;
    logic [5:0]      w_cmd_idx;
    logic [31:0]     w_cmd_wdata;
    logic            w_done;
    logic [31:0]     w_rdata;
    logic            w_accept;
    logic            w_hit;
    logic [TO_W-1:0] w_poll_inc;

    assign w_accept   = (r_fsm == S_IDLE) && job_valid_i;
    assign w_poll_inc = r_poll + 1'b1;

`ifdef AES0_SEQ_KEY_CACHE_EN
    logic [193:0] r_lk;
    logic         r_lk_vld;

    assign w_hit = r_lk_vld && (r_lk == {job_ksel_i, job_key_i});

    // Valid drops as soon as the key registers are being rewritten, so a
    // later timeout cannot leave a stale entry describing the peripheral.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lk     <= '0;
            r_lk_vld <= 1'b0;
        end else if (r_fsm == S_W_KSEL) begin
            r_lk_vld <= 1'b0;
        end else if (r_fsm == S_R_CT && w_done && r_wcnt == 3'd3) begin
            r_lk     <= {r_ksel, r_key};
            r_lk_vld <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_fsm <= S_IDLE;
        else         r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cmd_valid = 1'b0;
        w_cmd_we    = 1'b1;
        w_cmd_idx   = '0;
        w_cmd_wdata = '0;
        case (r_fsm)
            S_IDLE: begin
                if (job_valid_i) w_fsm_nxt = w_hit ? S_W_STATE : S_W_KSEL;
            end
            S_W_KSEL: begin
                w_cmd_valid = 1'b1;
                w_cmd_idx   = IDX_KSEL;
                w_cmd_wdata = {30'h0, r_ksel};
                if (w_done) w_fsm_nxt = S_W_KEY;
            end
            S_W_KEY: begin
                w_cmd_valid = 1'b1;
                w_cmd_idx   = key_base(r_ksel) + {3'b000, r_wcnt};
                w_cmd_wdata = r_key[{r_wcnt, 5'b00000} +: 32];
                if (w_done && r_wcnt == 3'd5) w_fsm_nxt = S_W_STATE;
            end
            S_W_STATE: begin
                w_cmd_valid = 1'b1;
                w_cmd_idx   = IDX_ST0 + {3'b000, r_wcnt};
                w_cmd_wdata = r_st[{r_wcnt[1:0], 5'b00000} +: 32];
                if (w_done && r_wcnt == 3'd3) w_fsm_nxt = S_W_PT;
            end
            S_W_PT: begin
                w_cmd_valid = 1'b1;
                w_cmd_idx   = IDX_PT0 + {3'b000, r_wcnt};
                w_cmd_wdata = r_pt[{r_wcnt[1:0], 5'b00000} +: 32];
                if (w_done && r_wcnt == 3'd3) w_fsm_nxt = S_W_START1;
            end
            S_W_START1: begin
                w_cmd_valid = 1'b1;
                w_cmd_idx   = IDX_START;
                w_cmd_wdata = 32'd1;
                if (w_done) w_fsm_nxt = S_W_START0;
            end
            S_W_START0: begin
                w_cmd_valid = 1'b1;
                w_cmd_idx   = IDX_START;
                if (w_done) w_fsm_nxt = S_POLL;
            end
            S_POLL: begin
                w_cmd_valid = 1'b1;
                w_cmd_we    = 1'b0;
                w_cmd_idx   = IDX_VALID;
                if (w_done) begin
                    if (w_rdata[0])                           w_fsm_nxt = S_R_CT;
                    else if (w_poll_inc == TO_W'(POLL_MAX))   w_fsm_nxt = S_RESP;
                end
            end
            S_R_CT: begin
                w_cmd_valid = 1'b1;
                w_cmd_we    = 1'b0;
                w_cmd_idx   = IDX_CT0 + {3'b000, r_wcnt};
                if (w_done && r_wcnt == 3'd3) w_fsm_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready_i) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // Datapath: job capture, word counter, poll counter, result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wcnt <= '0;
            r_poll <= '0;
            r_key  <= '0;
            r_ksel <= '0;
            r_st   <= '0;
            r_pt   <= '0;
            r_ct   <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key  <= job_key_i;
                r_ksel <= job_ksel_i;
                r_st   <= job_state_i;
                r_pt   <= job_pt_i;
                r_poll <= '0;
                r_err  <= 1'b0;
            end

            if (r_fsm != w_fsm_nxt)                r_wcnt <= '0;
            else if (w_done && r_fsm != S_POLL)    r_wcnt <= r_wcnt + 1'b1;

            if (r_fsm == S_POLL && w_done && !w_rdata[0]) begin
                r_poll <= w_poll_inc;
                if (w_poll_inc == TO_W'(POLL_MAX)) begin
                    r_ct  <= '0;
                    r_err <= 1'b1;
                end
            end

            if (r_fsm == S_R_CT && w_done) begin
                r_ct[{r_wcnt[1:0], 5'b00000} +: 32] <= w_rdata;
                r_err <= 1'b0;
            end

            if (r_fsm == S_RESP && res_ready_i) r_poll <= '0;
        end
    end

    aes0_seq_bus_if #(.ADDR_W(ADDR_W)) u_bus_if (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_cmd_valid  (w_cmd_valid),
        .o_cmd_ready  (w_cmd_ready),
        .i_cmd_we     (w_cmd_we),
        .i_cmd_idx    (w_cmd_idx),
        .i_cmd_wdata  (w_cmd_wdata),
        .o_done       (w_done),
        .o_rdata      (w_rdata),
        .o_bus_req    (bus_req_o),
        .o_bus_we     (bus_we_o),
        .o_bus_addr   (bus_addr_o),
        .o_bus_wdata  (bus_wdata_o),
        .i_bus_gnt    (bus_gnt_i),
        .i_bus_rvalid (bus_rvalid_i),
        .i_bus_rdata  (bus_rdata_i)
    );

    assign job_ready_o = (r_fsm == S_IDLE);
    assign res_valid_o = (r_fsm == S_RESP);
    assign res_ct_o    = r_ct;
    assign res_err_o   = r_err;
    assign dbg_state_o = r_fsm;

endmodule
